// File: rtl/ps2_pkg.sv
// Shared types and constants for the multi-channel PS/2 device-side transmitter.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BIT0   = 4'd1,
        ST_BIT1   = 4'd2,
        ST_BIT2   = 4'd3,
        ST_BIT3   = 4'd4,
        ST_BIT4   = 4'd5,
        ST_BIT5   = 4'd6,
        ST_BIT6   = 4'd7,
        ST_BIT7   = 4'd8,
        ST_PARITY = 4'd9,
        ST_STOP   = 4'd10,
        ST_END    = 4'd11
    } ps2_state_t;

    localparam int FRAME_TICKS = 12;

endpackage

// File: rtl/ps2_tx_multi_if.sv
// Write/status/line bundle between the command decoder side and the PS/2 transmitter.
interface ps2_tx_multi_if #(
    parameter int CHANNELS = 2
);
    logic                wr_en;
    logic [2:0]          wr_chan;
    logic [7:0]          wr_data;
    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] overflow;
    logic [CHANNELS-1:0] ovf_clr;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] ps2_clk;
    logic [CHANNELS-1:0] ps2_data;
    logic [CHANNELS-1:0] ps2_clk_in;

    modport master (
        output wr_en, wr_chan, wr_data, ovf_clr, ps2_clk_in,
        input  fifo_full, overflow, busy, ps2_clk, ps2_data
    );

    modport slave (
        input  wr_en, wr_chan, wr_data, ovf_clr, ps2_clk_in,
        output fifo_full, overflow, busy, ps2_clk, ps2_data
    );
endinterface

// File: rtl/ps2_tx_chan.sv
// One PS/2 transmit channel: byte FIFO, sticky overflow and the 12-tick frame FSM.
// Host-inhibit abort/retransmit is built only when PS2_TX_INHIBIT_EN is defined.
module ps2_tx_chan
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tick_i,
    input  logic       clk_ps2_i,
    input  logic       clk_ps2_d_i,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       ovf_clr_i,
    input  logic       ps2_clk_in_i,
    output logic       fifo_full_o,
    output logic       overflow_o,
    output logic       busy_o,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] FULL_XOR = {1'b1, {FIFO_BITS{1'b0}}};

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
    ps2_state_t       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             full_q, busy_q, ps2_clk_q;
    logic             empty_s, full_s, push_s, pop_s;
    logic             inhibit_s, abort_s;

    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = ((wptr_q ^ rptr_q) == FULL_XOR);
    assign push_s  = wr_i & ~full_s;

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser on the sensed clock line, idle high.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_in_i};
        end
    end

    assign inhibit_s = ~sync_q[1];
    // Host holding clock low while we release it high: abandon the frame mid-way.
    assign abort_s   = inhibit_s & clk_ps2_i & (state_q != ST_IDLE) & (state_q != ST_END);
`else
    logic unused_s;
    assign unused_s  = ps2_clk_in_i ^ clk_ps2_i;
    assign inhibit_s = 1'b0;
    assign abort_s   = 1'b0;
`endif

    // Frame sequencer; the head byte stays queued until its frame completes.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        data_d   = data_q;
        pop_s    = 1'b0;
        if (abort_s) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
        end else if (tick_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s && !inhibit_s) begin
                        shift_d  = mem_q[rptr_q[FIFO_BITS-1:0]];
                        parity_d = 1'b1;
                        data_d   = 1'b0;
                        state_d  = ST_BIT0;
                    end else begin
                        data_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3,
                ST_BIT4, ST_BIT5, ST_BIT6, ST_BIT7: begin
                    data_d   = shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                    parity_d = parity_q ^ shift_q[0];
                    state_d  = ps2_state_t'(state_q + 4'd1);
                end
                ST_PARITY: begin
                    data_d  = parity_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    data_d  = 1'b1;
                    state_d = ST_END;
                end
                ST_END: begin
                    data_d  = 1'b1;
                    pop_s   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    data_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pointer and sticky-overflow next state; a dropped write beats a clear.
    always_comb begin
        wptr_d = push_s ? (wptr_q + {{FIFO_BITS{1'b0}}, 1'b1}) : wptr_q;
        rptr_d = pop_s  ? (rptr_q + {{FIFO_BITS{1'b0}}, 1'b1}) : rptr_q;
        if (wr_i && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk_sys) begin
        if (push_s) begin
            mem_q[wptr_q[FIFO_BITS-1:0]] <= wr_data_i;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            parity_q  <= 1'b1;
            data_q    <= 1'b1;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            ps2_clk_q <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            full_q    <= ((wptr_d ^ rptr_d) == FULL_XOR);
            busy_q    <= (state_d != ST_IDLE) || (wptr_d != rptr_d);
            ps2_clk_q <= clk_ps2_d_i | (state_d == ST_IDLE);
        end
    end

    assign fifo_full_o = full_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = busy_q;
    assign ps2_clk_o   = ps2_clk_q;
    assign ps2_data_o  = data_q;

endmodule

// File: rtl/ps2_tx_multi.sv
// N-channel PS/2 device transmitter: shared clock divider, write demux, per-channel engines.
// Optional host-inhibit handling is enabled with the PS2_TX_INHIBIT_EN macro.
module ps2_tx_multi
    import ps2_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    ps2_tx_multi_if.slave bus
);

    localparam int CW = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PS2DIV);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                clk_ps2_q, clk_ps2_d;
    logic                tick_q, tick_d;
    logic [CHANNELS-1:0] wr_sel_s;
    logic [CHANNELS-1:0] full_s, ovf_s, busy_s, clk_s, data_s;

    // Divider next state; tick marks the rising half of the PS/2 clock.
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        clk_ps2_d = clk_ps2_q;
        tick_d    = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            clk_ps2_d = ~clk_ps2_q;
            tick_d    = ~clk_ps2_q;
        end else begin
            tick_d    = 1'b0;
        end
    end

    // Divider registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            clk_ps2_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_ps2_q <= clk_ps2_d;
            tick_q    <= tick_d;
        end
    end

    // Write demux; channel numbers beyond CHANNELS match nothing.
    always_comb begin
        wr_sel_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sel_s[c] = bus.wr_en && (bus.wr_chan == 3'(c));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ps2_tx_chan #(
            .FIFO_BITS (FIFO_BITS)
        ) u_chan (
            .clk_sys      (clk_sys),
            .reset_n      (reset_n),
            .tick_i       (tick_q),
            .clk_ps2_i    (clk_ps2_q),
            .clk_ps2_d_i  (clk_ps2_d),
            .wr_i         (wr_sel_s[g]),
            .wr_data_i    (bus.wr_data),
            .ovf_clr_i    (bus.ovf_clr[g]),
            .ps2_clk_in_i (bus.ps2_clk_in[g]),
            .fifo_full_o  (full_s[g]),
            .overflow_o   (ovf_s[g]),
            .busy_o       (busy_s[g]),
            .ps2_clk_o    (clk_s[g]),
            .ps2_data_o   (data_s[g])
        );
    end

    assign bus.fifo_full = full_s;
    assign bus.overflow  = ovf_s;
    assign bus.busy      = busy_s;
    assign bus.ps2_clk   = clk_s;
    assign bus.ps2_data  = data_s;

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Directed bench for ps2_tx_multi with PS2DIV=4 (10-cycle PS/2 period), two channels.
module tb_ps2_tx_multi;
    import ps2_pkg::*;

    localparam int CH  = 2;
    localparam int FB  = 3;
    localparam int DIV = 4;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   falls   = 0;
    int   f0      = 0;
    logic prev_clk0 = 1'b1;
    logic par3 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk_sys = ~clk_sys;

    ps2_tx_multi_if #(.CHANNELS(CH)) bus ();

    ps2_tx_multi #(
        .CHANNELS  (CH),
        .FIFO_BITS (FB),
        .PS2DIV    (DIV)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Edges since reset release; state updates land on edges with cyc%10==6.
    always @(posedge clk_sys) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk_sys) begin
        if (prev_clk0 && !bus.ps2_clk[0]) falls <= falls + 1;
        prev_clk0 <= bus.ps2_clk[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        bit found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            @(posedge clk_sys);
            #1;
            if (cyc % 10 == 6) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL tick_wait observed=0 expected=1");
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_chan = ch;
        bus.wr_data = d;
        @(posedge clk_sys);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] b, input logic p, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return b[k-1];
        else if (k == 9) return p;
        else             return 1'b1;
    endfunction

    task automatic do_tick(input logic [1:0] ed, input logic [1:0] ec, input string tag);
        next_tick();
        chk({tag, "_data"}, 32'(bus.ps2_data), 32'(ed));
        repeat (5) @(posedge clk_sys);
        #1;
        chk({tag, "_clk"}, 32'(bus.ps2_clk), 32'(ec));
    endtask

    task automatic run_frames(input logic [1:0] en, input logic [7:0] b0, input logic p0,
                              input logic [7:0] b1, input logic p1,
                              input logic [1:0] busy_end, input string tag);
        logic [1:0] ed, ec;
        for (int k = 0; k < FRAME_TICKS; k++) begin
            ed[0] = en[0] ? fbit(b0, p0, k) : 1'b1;
            ed[1] = en[1] ? fbit(b1, p1, k) : 1'b1;
            ec[0] = !(en[0] && (k < FRAME_TICKS - 1));
            ec[1] = !(en[1] && (k < FRAME_TICKS - 1));
            do_tick(ed, ec, $sformatf("%s_k%0d", tag, k));
        end
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'(busy_end));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_chan    = 3'd0;
        bus.wr_data    = 8'h00;
        bus.ovf_clr    = 2'b00;
        bus.ps2_clk_in = 2'b11;
        reset_n        = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_clk",  32'(bus.ps2_clk),   32'h3);
        chk("rst_data", 32'(bus.ps2_data),  32'h3);
        chk("rst_busy", 32'(bus.busy),      32'h0);
        chk("rst_full", 32'(bus.fifo_full), 32'h0);
        chk("rst_ovf",  32'(bus.overflow),  32'h0);
        reset_n = 1'b1;

        // Single 0x5A frame on channel 0
        next_tick();
        f0 = falls;
        wr(3'd0, 8'h5A);
        chk("t1_busy_wr", 32'(bus.busy),      32'h1);
        chk("t1_full_wr", 32'(bus.fifo_full), 32'h0);
        run_frames(2'b01, 8'h5A, 1'b1, 8'h00, 1'b0, 2'b00, "t1");
        chk("t1_clk_pulses", 32'(falls - f0), 32'd11);

        // Back-to-back frames with parity 1,1,0
        next_tick();
        wr(3'd0, 8'h00);
        wr(3'd0, 8'hFF);
        wr(3'd0, 8'h01);
        run_frames(2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 2'b01, "t2a");
        run_frames(2'b01, 8'hFF, 1'b1, 8'h00, 1'b0, 2'b01, "t2b");
        run_frames(2'b01, 8'h01, 1'b0, 8'h00, 1'b0, 2'b00, "t2c");

        // Nine writes inside one PS/2 period: eight fit, the ninth overflows
        next_tick();
        for (int i = 0; i < 9; i++) begin
            wr(3'd0, 8'h10 + 8'(i));
            chk($sformatf("t3_full_w%0d", i), 32'(bus.fifo_full), (i >= 7) ? 32'h1 : 32'h0);
            chk($sformatf("t3_ovf_w%0d", i),  32'(bus.overflow),  (i == 8) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            run_frames(2'b01, 8'h10 + 8'(i), par3[i], 8'h00, 1'b0,
                       (i < 7) ? 2'b01 : 2'b00, $sformatf("t3f%0d", i));
            if (i == 0) begin
                chk("t3_ovf_sticky", 32'(bus.overflow),  32'h1);
                chk("t3_full_pop",   32'(bus.fifo_full), 32'h0);
                bus.ovf_clr = 2'b01;
                @(posedge clk_sys);
                #1;
                bus.ovf_clr = 2'b00;
                chk("t3_ovf_clr", 32'(bus.overflow), 32'h0);
            end
        end
        do_tick(2'b11, 2'b11, "t3_no_ninth");

        // Parallel channels; writes to channels 2 and 7 go nowhere
        next_tick();
        wr(3'd0, 8'h12);
        wr(3'd1, 8'h34);
        wr(3'd2, 8'h99);
        wr(3'd7, 8'h77);
        chk("t4_busy_wr", 32'(bus.busy), 32'h3);
        run_frames(2'b11, 8'h12, 1'b1, 8'h34, 1'b0, 2'b00, "t4");
        do_tick(2'b11, 2'b11, "t4_idle");
        chk("t4_busy_idle", 32'(bus.busy), 32'h0);

        // Host pulls clock low at state 5 for 30 cycles
        next_tick();
        wr(3'd0, 8'h5A);
        for (int k = 0; k < 5; k++)
            do_tick({1'b1, fbit(8'h5A, 1'b1, k)}, 2'b10, $sformatf("t5_k%0d", k));
        bus.ps2_clk_in[0] = 1'b0;
`ifdef PS2_TX_INHIBIT_EN
        for (int k = 5; k < 8; k++)
            do_tick(2'b11, 2'b11, $sformatf("t5_inh%0d", k));
        chk("t5_busy_inh", 32'(bus.busy), 32'h1);
        bus.ps2_clk_in[0] = 1'b1;
        run_frames(2'b01, 8'h5A, 1'b1, 8'h00, 1'b0, 2'b00, "t5_resend");
`else
        for (int k = 5; k < 8; k++)
            do_tick({1'b1, fbit(8'h5A, 1'b1, k)}, 2'b10, $sformatf("t5_k%0d", k));
        bus.ps2_clk_in[0] = 1'b1;
        for (int k = 8; k < FRAME_TICKS; k++)
            do_tick({1'b1, fbit(8'h5A, 1'b1, k)}, (k < FRAME_TICKS - 1) ? 2'b10 : 2'b11,
                    $sformatf("t5_k%0d", k));
        chk("t5_busy_end", 32'(bus.busy), 32'h0);
`endif

        // Reset mid-frame with three bytes queued
        next_tick();
        wr(3'd0, 8'hA1);
        wr(3'd0, 8'hB2);
        wr(3'd0, 8'hC3);
        for (int k = 0; k < 6; k++)
            do_tick({1'b1, fbit(8'hA1, 1'b0, k)}, 2'b10, $sformatf("t6_k%0d", k));
        reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("t6_rst_clk",  32'(bus.ps2_clk),   32'h3);
        chk("t6_rst_data", 32'(bus.ps2_data),  32'h3);
        chk("t6_rst_busy", 32'(bus.busy),      32'h0);
        chk("t6_rst_full", 32'(bus.fifo_full), 32'h0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++)
            do_tick(2'b11, 2'b11, $sformatf("t6_after%0d", k));
        chk("t6_busy_after", 32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
